vec_out_serializer: RTL

//  Transmit side of the host byte link. Captures one N-element vector in parallel from the

---
 rtl/vec_out_serializer.sv | 68 ++++++
 1 files changed

// File: rtl/vec_out_serializer.sv
// vec_out_serializer: captures an N-element vector and streams it as bytes over valid/ready
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   load, vec_in      start a transfer of vec_in (element i = vec_in[i*W +: W]), IDLE only
//   tx_data/valid     byte offered to the link, held stable until tx_ready accepts it
//   tx_ready          link accepts tx_data this cycle
//   busy              transfer in progress (HDR, DATA, DONE)
//   done              one-cycle pulse in the cycle after the last byte is accepted
//   overrun           one-cycle pulse after a load that arrived while busy and was dropped
module vec_out_serializer #(
   parameter int N      = 16,
   parameter int W      = 8,
   parameter bit HDR_EN = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic [N*W-1:0] vec_in,
   output logic [W-1:0]   tx_data,
   output logic           tx_valid,
   input  logic           tx_ready,
   output logic           busy,
   output logic           done,
   output logic           overrun
);
   localparam int IW = $clog2(N);
   localparam logic [W-1:0] HB = W'(N);
   typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;
   state_t state, state_n;
   logic [IW-1:0] idx;
   logic [N*W-1:0] sreg;
   logic accept, last;
   assign accept   = tx_valid && tx_ready;
   assign last     = idx == IW'(N - 1);
   assign tx_valid = state == HDR || state == DATA;
   assign busy     = state != IDLE;
   // element idx always sits in the low byte because the register shifts on each data accept
   assign tx_data  = state == HDR ? HB : state == DATA ? sreg[W-1:0] : '0;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = load ? (HDR_EN ? HDR : DATA) : IDLE;
         HDR:     state_n = accept ? DATA : HDR;
         DATA:    state_n = accept && last ? DONE : DATA;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         sreg    <= '0;
         done    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= state_n;
         done    <= state == DATA && accept && last;
         overrun <= load && state != IDLE;
         if (state == IDLE && load) begin
            sreg <= vec_in;
            idx  <= '0;
         end else if (state == DATA && accept) begin
            sreg <= sreg >> W;
            idx  <= last ? idx : idx + 1'b1;
         end
      end
   end
endmodule
